// File: rtl/round_sat_pipe_pkg.sv
// round_sat_pipe shared definitions.
// Rounding-mode codes and sign-magnitude field geometry.
package round_sat_pipe_pkg;

    localparam logic [1:0] RM_TRUNC     = 2'b00;
    localparam logic [1:0] RM_HALF_AWAY = 2'b01;
    localparam logic [1:0] RM_HALF_EVEN = 2'b10;

    localparam int DEF_IN_W   = 32;
    localparam int DEF_FRAC_W = 16;
    localparam int DEF_OUT_W  = 8;

    // Bit position of the sign in a sample.
    function automatic int sm_sign_pos(input int in_w);
        return in_w - 1;
    endfunction

    // Width of the integer part of the magnitude.
    function automatic int sm_q_w(input int in_w, input int frac_w);
        return in_w - 1 - frac_w;
    endfunction

    // Rounded magnitude width: one carry bit above q.
    function automatic int sm_r_w(input int in_w, input int frac_w);
        return in_w - frac_w;
    endfunction

    // Signed rounded value width.
    function automatic int sm_v_w(input int in_w, input int frac_w);
        return in_w - frac_w + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/round_sat_pipe_if.sv
// round_sat_pipe streaming bus.
// Input beat channel and output beat channel, valid/ready each.
interface round_sat_pipe_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    modport master (
        output in_valid,
        output in_data,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat
    );

endinterface

// File: rtl/round_sat_pipe_round_core.sv
// round_core: combinational sign-magnitude fixed-point rounder.
// Produces a two's complement integer; negative zero maps to 0.
module round_core
    import round_sat_pipe_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int FRAC_W = 16
) (
    input  logic [IN_W-1:0]          data_i,
    input  logic [1:0]               mode_i,
    output logic signed [IN_W-FRAC_W:0] val_o
);

    localparam int Q_W = sm_q_w(IN_W, FRAC_W);
    localparam int R_W = sm_r_w(IN_W, FRAC_W);
    localparam int V_W = sm_v_w(IN_W, FRAC_W);
    localparam int S_P = sm_sign_pos(IN_W);

    logic                  sign;
    logic [Q_W-1:0]        q;
    logic [FRAC_W-1:0]     f;
    logic [FRAC_W-1:0]     h;
    logic                  inc;
    logic [R_W-1:0]        r;
    logic signed [V_W-1:0] mag_s;

    assign sign = data_i[S_P];
    assign q    = data_i[IN_W-2:FRAC_W];
    assign f    = data_i[FRAC_W-1:0];

    // Half-LSB weight of the fractional field.
    always_comb begin
        h = '0;
        h[FRAC_W-1] = 1'b1;
    end

    // Round-up decision; the reserved mode code rounds half away.
    always_comb begin
        inc = 1'b0;
        unique case (mode_i)
            RM_TRUNC:     inc = 1'b0;
            RM_HALF_EVEN: inc = (f > h) || ((f == h) && q[0]);
            default:      inc = (f >= h);
        endcase
    end

    // Magnitude add cannot overflow thanks to the carry bit; negate last.
    always_comb begin
        r     = {1'b0, q} + R_W'(inc);
        mag_s = {1'b0, r};
        val_o = sign ? -mag_s : mag_s;
    end

endmodule

// File: rtl/round_sat_pipe.sv
// round_sat_pipe: two-stage round / level-shift / saturate stream.
// Stage 1 rounds, stage 2 shifts and clamps; counts clamped beats.
module round_sat_pipe
    import round_sat_pipe_pkg::*;
#(
    parameter int IN_W        = 32,
    parameter int FRAC_W      = 16,
    parameter int OUT_W       = 8,
    parameter int OUT_SIGNED  = 0,
    parameter int LEVEL_SHIFT = 128,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    round_sat_pipe_if.slave    io,
    input  logic               sat_clr,
    output logic [CNT_W-1:0]   sat_count
);

    localparam int V_W = sm_v_w(IN_W, FRAC_W);
    localparam int W_W = max3(V_W, OUT_W, 32) + 1;
    localparam logic signed [W_W-1:0] LS = W_W'(LEVEL_SHIFT);

    logic signed [V_W-1:0] core_v;

    logic                  s1_valid_q, s1_valid_d;
    logic signed [V_W-1:0] s1_v_q, s1_v_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0]      s2_data_q, s2_data_d;
    logic                  s2_sat_q, s2_sat_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  s1_adv;
    logic                  s2_adv;
    logic signed [W_W-1:0] vx;
    logic signed [W_W-1:0] w;
    logic [OUT_W-1:0]      sat_data;
    logic                  sat_flag;

    round_core #(
        .IN_W   (IN_W),
        .FRAC_W (FRAC_W)
    ) u_round (
        .data_i (io.in_data),
        .mode_i (io.in_mode),
        .val_o  (core_v)
    );

    // Widen the stage-1 value, apply the shift and clamp to the range.
    always_comb begin
        vx       = {{(W_W-V_W){s1_v_q[V_W-1]}}, s1_v_q};
        w        = vx + LS;
        sat_data = '0;
        sat_flag = 1'b0;
        if (OUT_SIGNED != 0) begin
            if ((vx[W_W-1:OUT_W-1] == '0) || (vx[W_W-1:OUT_W-1] == '1)) begin
                sat_data = vx[OUT_W-1:0];
            end else if (vx[W_W-1]) begin
                sat_data[OUT_W-1] = 1'b1;
                sat_flag = 1'b1;
            end else begin
                sat_data = '1;
                sat_data[OUT_W-1] = 1'b0;
                sat_flag = 1'b1;
            end
        end else begin
            if (w[W_W-1]) begin
                sat_data = '0;
                sat_flag = 1'b1;
            end else if (w[W_W-2:OUT_W] != '0) begin
                sat_data = '1;
                sat_flag = 1'b1;
            end else begin
                sat_data = w[OUT_W-1:0];
            end
        end
    end

    // Stall control and next state of both stages and the counter.
    always_comb begin
        s2_adv     = !s2_valid_q || io.out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_valid_d = s1_valid_q;
        s1_v_d     = s1_v_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        cnt_d      = cnt_q;
        if (s1_adv) begin
            s1_valid_d = io.in_valid;
            if (io.in_valid) begin
                s1_v_d = core_v;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = sat_data;
                s2_sat_d  = sat_flag;
            end
        end
        if (sat_clr) begin
            cnt_d = '0;
        end else if (s2_valid_q && io.out_ready && s2_sat_q && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline and counter registers; reset drops all in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_v_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_v_q     <= s1_v_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            cnt_q      <= cnt_d;
        end
    end

    assign io.in_ready  = s1_adv;
    assign io.out_valid = s2_valid_q;
    assign io.out_data  = s2_data_q;
    assign io.out_sat   = s2_sat_q;
    assign sat_count    = cnt_q;

endmodule

// File: doc/round_sat_pipe.md
Name: round_sat_pipe

Overview:
- Parametrised, pipelined successor to the Filter-stage float-to-integer rounder.
- Converts sign-magnitude fixed-point samples (1 sign bit, IN_W-1 magnitude bits, FRAC_W of them fractional) to integers.
- Rounding mode is selectable per beat; optional level shift; saturation to OUT_W.
- Sits between the IDCT/filter datapath and the pixel writer; valid/ready streaming, with a saturation-event counter for debug.

Parameters:
- IN_W, 32, total input width (bit IN_W-1 = sign, rest magnitude); IN_W >= FRAC_W+2.
- FRAC_W, 16, fractional magnitude bits; 1 <= FRAC_W <= IN_W-2.
- OUT_W, 8, output integer width.
- OUT_SIGNED, 0, 1 = saturate to signed [-2^(OUT_W-1), 2^(OUT_W-1)-1]; 0 = add LEVEL_SHIFT then clamp to [0, 2^OUT_W-1].
- LEVEL_SHIFT, 128, signed offset added when OUT_SIGNED=0; ignored otherwise.
- CNT_W, 16, saturation counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  IN_W  sign-magnitude fixed-point sample.
- in_mode  in  2  00 truncate, 01 half-away-from-zero, 10 half-to-even, 11 treated as 01.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  rounded, shifted, saturated integer (two's complement if OUT_SIGNED=1).
- out_sat  out  1  this beat was clamped.
- sat_count  out  CNT_W  number of clamped beats delivered.
- sat_clr  in  1  synchronous clear of sat_count.

Behaviour:
- Reset (async, rst_n=0): stage valids, out_valid, out_data, out_sat and sat_count all go to 0; in_ready=1 after release. Reset mid-stream discards in-flight beats; no partial output.
- Transfer rule: a transfer occurs when valid && ready on the same rising edge. in_data and in_mode are sampled only on transfer.
- Stage 1 (round):
  - m = magnitude, q = m >> FRAC_W, f = m[FRAC_W-1:0], h = 1 << (FRAC_W-1).
  - Truncate: r = q.
  - Half-away: r = q + (f >= h).
  - Half-even: r = q + (f > h || (f == h && q[0])).
  - r is held unsigned in IN_W-FRAC_W bits; no overflow is possible.
  - Signed result v = sign ? -r : r, in IN_W-FRAC_W+1 bits.
  - Negative zero (sign=1, r=0) yields v=0.
- Stage 2 (shift/saturate):
  - OUT_SIGNED=0: w = v + LEVEL_SHIFT, computed with one guard bit; clamp to [0, 2^OUT_W-1].
  - OUT_SIGNED=1: clamp v to the signed range.
  - out_sat = 1 iff clamping changed the value.
- Pipeline control:
  - Two register stages; latency exactly 2 cycles from input transfer to out_valid when out_ready=1.
  - Throughput 1 beat/cycle.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready, no combinational path from in_valid).
  - Under back-pressure, at most 2 beats are held. Order is preserved; no beat is dropped or duplicated.
- out_data/out_sat are held stable while out_valid && !out_ready.
- sat_count:
  - Increments on each output transfer with out_sat=1.
  - Sticks at all-ones (no wrap).
  - sat_clr has priority over a same-cycle increment: result is 0.

Decomposition:
- Shared package holds:
  - rounding-mode constants (RM_TRUNC=2'b00, RM_HALF_AWAY=2'b01, RM_HALF_EVEN=2'b10);
  - the sign-magnitude field-extraction localparams.
- One natural sub-module: round_core, the combinational Stage-1 rounding logic (sign-magnitude in, signed integer out, mode input). It can replace the legacy rounder elsewhere.

Test Plan:
All cases use default parameters unless stated; mag=0x28000 means 2.5.
- Positive 2.5: sign=0, mag=0x28000. Mode 01 -> out_data=131; mode 10 -> 130; mode 00 -> 130; out_sat=0 in all three; each output 2 cycles after acceptance.
- Negative 2.5: sign=1, mag=0x28000. Mode 01 -> 125 (-3+128); mode 10 -> 126; mode 00 -> 126. Also sign=1, mag=0x4000 (-0.25), mode 00 -> 128 (no negative-zero artefact).
- Saturation, positive: +200.0 (mag=0xC80000) -> 255, out_sat=1.
- Saturation, negative: -300.0 -> 0, out_sat=1.
- Counter: sat_count=2 after the two saturating beats. Pulse sat_clr in the same cycle as a third saturating output -> sat_count=0.
- Signed mode (OUT_SIGNED=1):
  - +127.5, mode 10 -> 127 (half-even, q=127 is odd -> 128, clamped to 127, out_sat=1).
  - -128.4, mode 01 -> -128, out_sat=0.
- Back-pressure: stream 10 beats (values 0..9.0) with in_valid held high; hold out_ready=0 for cycles 3-7. Required: in_ready deasserts with 2 beats held; out_data stays stable while stalled; outputs are 128..137 in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 asynchronously with 2 beats in flight. Required: out_valid drops immediately and sat_count=0. After release, the first new input appears 2 cycles after acceptance.
